div_seq: RTL

//   Multi-cycle sequencer for the DIV/DIVU operations of the EX stage.
//   EX asserts start_i with both operands; the block runs a radix-2 restoring

---
 rtl/div_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit is produced per clock over WIDTH cycles. Signed operations
// divide magnitudes and apply a sign fix-up when the result is registered.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend, sampled on an accepted start
//   opdata2_i     divisor, sampled on an accepted start
//   start_i       request, held high until the result is consumed
//   annul_i       abort the operation in progress (flush / exception)
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
//   busy_o        high while a division is pending (stall request)
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_e             state_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH:0]   dvd_q;     // {partial remainder, dividend/quotient bits}
  logic [2*WIDTH:0]   dvd_d;
  logic [WIDTH-1:0]   dvs_q;     // divisor magnitude
  logic               sgn_q;
  logic               sign1_q;
  logic               sign2_q;
  logic [2*WIDTH-1:0] res_q;     // result captured on END entry

  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   quo_raw;
  logic [WIDTH-1:0]   rem_raw;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;

  // Magnitudes of the incoming operands; only signed requests are negated.
  always_comb begin
    abs1 = opdata1_i;
    abs2 = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) abs1 = '0 - opdata1_i;
    if (signed_div_i && opdata2_i[WIDTH-1]) abs2 = '0 - opdata2_i;
  end

  // One restoring step: shift, trial-subtract on WIDTH+1 bits, keep or restore.
  always_comb begin
    shifted = dvd_q << 1;
    ge      = shifted[2*WIDTH:WIDTH] >= {1'b0, dvs_q};
    diff    = shifted[2*WIDTH:WIDTH] - {1'b0, dvs_q};
    dvd_d   = shifted;
    if (ge) dvd_d = {diff, shifted[WIDTH-1:1], 1'b1};
  end

  // Sign fix-up of the final step's outcome; negation wraps modulo 2^WIDTH.
  always_comb begin
    quo_raw = dvd_d[WIDTH-1:0];
    rem_raw = dvd_d[2*WIDTH-1:WIDTH];
    quo_fix = quo_raw;
    rem_fix = rem_raw;
    if (sgn_q && (sign1_q != sign2_q)) quo_fix = '0 - quo_raw;
    if (sgn_q && sign1_q)              rem_fix = '0 - rem_raw;
  end

  always_comb begin
    busy_o = (state_q == S_BYZERO) || (state_q == S_ON);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      res_q    <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= S_BYZERO;
            end else begin
              sgn_q   <= signed_div_i;
              sign1_q <= opdata1_i[WIDTH-1];
              sign2_q <= opdata2_i[WIDTH-1];
              dvd_q   <= {{(WIDTH+1){1'b0}}, abs1};
              dvs_q   <= abs2;
              cnt_q   <= '0;
              state_q <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            res_q   <= '0;
            state_q <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == LAST_ITER) begin
              res_q   <= {rem_fix, quo_fix};
              state_q <= S_END;
            end
          end
        end
        S_END: begin
          // Result is presented one edge after END entry and held while
          // EX keeps start_i high.
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= res_q;
          end else begin
            ready_o  <= 1'b0;
            result_o <= '0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
